sram_bus_arbiter: RTL and testbench

//   Shares one SRAM-like master port (req/wr/size/addr/wdata, addr_ok/data_ok/rdata) between the

---
 rtl/sram_bus_arbiter_pkg.sv | 21 ++
 rtl/sram_bus_arbiter_grant_sel.sv | 25 ++
 rtl/sram_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_sram_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM bus arbiter: FSM states, bus owner and
// transfer size codes.
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } arb_owner_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/sram_bus_arbiter_grant_sel.sv
// Combinational winner select between the fetch and data ports.
// A lone requester always wins. On a tie, the port that did not win last
// time is chosen; tying last_grant_data low gives fixed data-over-inst.
module sram_bus_arbiter_grant_sel (
    input  logic inst_req,
    input  logic data_req,
    input  logic last_grant_data,
    output logic grant_inst,
    output logic grant_data
);

    // Pick at most one winner from the current requests
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (inst_req && data_req) begin
            grant_data = !last_grant_data;
            grant_inst = last_grant_data;
        end else begin
            grant_inst = inst_req;
            grant_data = data_req;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like master port between instruction fetch and data
// memory, one transaction outstanding at a time (IDLE -> ADDR -> DATA).
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// otherwise data wins ties over inst.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    arb_state_t        state;
    arb_owner_t        owner;
    logic              lat_wr;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              grant_inst;
    logic              grant_data;
    logic              last_grant_data;
    logic              in_addr;

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority: behave as if inst was granted last, so data wins ties
    assign last_grant_data = 1'b0;
`endif

    sram_bus_arbiter_grant_sel u_grant_sel (
        .inst_req        (inst_req),
        .data_req        (data_req),
        .last_grant_data (last_grant_data),
        .grant_inst      (grant_inst),
        .grant_data      (grant_data)
    );

    // Transaction FSM: grant and latch in IDLE, hold the request in ADDR,
    // wait for the response in DATA; owner is cleared when the bus is free
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            owner     <= OWN_NONE;
            lat_wr    <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= '0;
            lat_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_data <= 1'b0;
`endif
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (grant_data) begin
                        state     <= ARB_ADDR;
                        owner     <= OWN_DATA;
                        lat_wr    <= data_wr;
                        lat_size  <= data_size;
                        lat_addr  <= data_addr;
                        lat_wdata <= data_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_data <= 1'b1;
`endif
                    end else if (grant_inst) begin
                        state     <= ARB_ADDR;
                        owner     <= OWN_INST;
                        lat_wr    <= 1'b0;
                        lat_size  <= SIZE_W;
                        lat_addr  <= inst_addr;
                        lat_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_data <= 1'b0;
`endif
                    end
                end
                ARB_ADDR: begin
                    if (bus_addr_ok) begin
                        state <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (bus_data_ok) begin
                        state <= ARB_IDLE;
                        owner <= OWN_NONE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

    // Bus fields are only driven while the address phase is open
    assign in_addr   = (state == ARB_ADDR);
    assign bus_req   = in_addr;
    assign bus_wr    = in_addr & lat_wr;
    assign bus_size  = in_addr ? lat_size : 2'b00;
    assign bus_addr  = in_addr ? lat_addr : '0;
    assign bus_wdata = in_addr ? lat_wdata : '0;
    assign busy      = (state != ARB_IDLE);

    // Handshakes route straight through to the owner only
    assign inst_addr_ok = in_addr && bus_addr_ok && (owner == OWN_INST);
    assign data_addr_ok = in_addr && bus_addr_ok && (owner == OWN_DATA);
    assign inst_data_ok = (state == ARB_DATA) && bus_data_ok && (owner == OWN_INST);
    assign data_data_ok = (state == ARB_DATA) && bus_data_ok && (owner == OWN_DATA);
    assign inst_rdata   = (owner == OWN_INST) ? bus_rdata : '0;
    assign data_rdata   = (owner == OWN_DATA) ? bus_rdata : '0;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Testbench for sram_bus_arbiter: directed transactions with a scoreboard
// of expected handshake pulses consumed by an independent monitor.
module tb_sram_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // pulses = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}
    typedef struct packed {
        logic [3:0]  pulses;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pulse must match the head of the scoreboard
    always @(negedge clock) begin
        logic [3:0] act;
        exp_t e;
        act = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
        if (act != 4'b0000) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse got %b expected none", act);
            end else begin
                e = sb_q.pop_front();
                chk("pulse", act, e.pulses);
                if (act[2]) begin
                    chk("inst_rdata", inst_rdata, e.rdata);
                    chk("nonowner_data_rdata", data_rdata, 0);
                end
                if (act[0]) begin
                    chk("data_rdata", data_rdata, e.rdata);
                    chk("nonowner_inst_rdata", inst_rdata, 0);
                end
            end
        end
    end

    // Bus slave for one transaction; called at posedge+1 with the request
    // already raised. Returns at posedge+1 of the IDLE bubble cycle.
    task automatic serve(input int own, input int aw, input int dw, input logic [31:0] rd,
                         input logic [31:0] ea, input logic ew, input logic [1:0] es,
                         input logic [31:0] ewd, input bit keep);
        int n;
        exp_t e;
        n = 0;
        while (!bus_req && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("grant_latency", n, 1);
        chk("bus_addr", bus_addr, ea);
        chk("bus_wr", bus_wr, ew);
        chk("bus_size", bus_size, es);
        chk("bus_wdata", bus_wdata, ewd);
        repeat (aw) begin
            @(posedge clock); #1;
            chk("stall_req", bus_req, 1);
            chk("stall_addr", bus_addr, ea);
            chk("stall_wr", bus_wr, ew);
            chk("stall_size", bus_size, es);
        end
        bus_addr_ok = 1'b1;
        e.pulses = (own == 1) ? 4'b1000 : 4'b0010;
        e.rdata  = 32'h0;
        sb_q.push_back(e);
        @(posedge clock); #1;
        bus_addr_ok = 1'b0;
        if (!keep) begin
            if (own == 1) inst_req = 1'b0;
            else data_req = 1'b0;
        end
        chk("data_phase_req", bus_req, 0);
        chk("data_phase_busy", busy, 1);
        repeat (dw - 1) begin
            @(posedge clock); #1;
            chk("data_wait_busy", busy, 1);
        end
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        e.pulses = (own == 1) ? 4'b0100 : 4'b0001;
        e.rdata  = rd;
        sb_q.push_back(e);
        @(posedge clock); #1;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        chk("bubble_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'b00;
        data_addr = 32'h0; data_wdata = 32'h0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;

        // Reset state
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_bus_req", bus_req, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("post_reset_busy", busy, 0);

        // 1: lone fetch, addr_ok in first ADDR cycle, data two cycles later
        @(posedge clock); #1;
        inst_req  = 1'b1;
        inst_addr = 32'h1FC0_0000;
        chk("idle_no_req_yet", bus_req, 0);
        serve(1, 0, 2, 32'h3C1D_8000, 32'h1FC0_0000, 1'b0, 2'b10, 32'h0, 1'b0);

        // 2: tie -> data first; data re-requests for a second tie
        inst_req   = 1'b1;
        inst_addr  = 32'h1FC0_0040;
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_size  = 2'b10;
        data_addr  = 32'h0000_1000;
        data_wdata = 32'h0;
        serve(2, 0, 1, 32'h1111_2222, 32'h0000_1000, 1'b0, 2'b10, 32'h0, 1'b1);
        data_addr = 32'h0000_1004;
`ifdef ARB_ROUND_ROBIN_EN
        serve(1, 0, 1, 32'h3333_4444, 32'h1FC0_0040, 1'b0, 2'b10, 32'h0, 1'b0);
        serve(2, 0, 1, 32'h5555_6666, 32'h0000_1004, 1'b0, 2'b10, 32'h0, 1'b0);
`else
        serve(2, 0, 1, 32'h5555_6666, 32'h0000_1004, 1'b0, 2'b10, 32'h0, 1'b0);
        serve(1, 0, 1, 32'h3333_4444, 32'h1FC0_0040, 1'b0, 2'b10, 32'h0, 1'b0);
`endif

        // 3: byte store
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'b00;
        data_addr  = 32'h0000_2003;
        data_wdata = 32'hABAB_ABAB;
        serve(2, 1, 1, 32'h0, 32'h0000_2003, 1'b1, 2'b00, 32'hABAB_ABAB, 1'b0);

        // 4: word store with address phase stalled five cycles
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'b10;
        data_addr  = 32'h0000_3000;
        data_wdata = 32'h1234_5678;
        serve(2, 5, 2, 32'h0, 32'h0000_3000, 1'b1, 2'b10, 32'h1234_5678, 1'b0);
        data_wr = 1'b0;

        // 5: reset during DATA, late bus_data_ok is ignored
        inst_req  = 1'b1;
        inst_addr = 32'h1FC0_0100;
        @(posedge clock); #1;
        chk("t5_bus_req", bus_req, 1);
        bus_addr_ok = 1'b1;
        sb_q.push_back('{pulses: 4'b1000, rdata: 32'h0});
        @(posedge clock); #1;
        bus_addr_ok = 1'b0;
        inst_req    = 1'b0;
        chk("t5_in_data_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("t5_reset_busy", busy, 0);
        chk("t5_reset_outputs", |{bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
                                  inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("t5_no_data_ok", inst_data_ok, 0);
        chk("t5_inst_rdata", inst_rdata, 0);
        chk("t5_busy", busy, 0);
        @(posedge clock); #1;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        chk("t5_still_idle", busy, 0);

        // 6: stray bus handshakes in IDLE
        bus_data_ok = 1'b1;
        bus_addr_ok = 1'b1;
        bus_rdata   = 32'h55AA_55AA;
        @(negedge clock);
        chk("t6_outputs_zero", |{bus_req, bus_wr, bus_size, bus_addr, bus_wdata, busy,
                                 inst_addr_ok, inst_data_ok, inst_rdata,
                                 data_addr_ok, data_data_ok, data_rdata}, 0);
        @(posedge clock); #1;
        chk("t6_busy_after", busy, 0);
        bus_data_ok = 1'b0;
        bus_addr_ok = 1'b0;
        bus_rdata   = 32'h0;

        repeat (2) @(posedge clock);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
